// File: rtl/decoder_pkg.sv
// Shared types and sizes for the decoder scan sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package decoder_pkg;

  localparam int CH_N  = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    GAP   = 2'd2
  } scan_state_t;

endpackage

// File: rtl/next_chan_pick.sv
// Circular priority search: next set mask bit above cur, optionally wrapping to the lowest.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module next_chan_pick
  import decoder_pkg::*;
(
  input  logic [CH_N-1:0]  mask,
  input  logic [IDX_W-1:0] cur,
  input  logic             wrap_en,
  output logic [IDX_W-1:0] nxt,
  output logic             found,
  output logic [IDX_W-1:0] first_idx
);

  logic             above_found;
  logic [IDX_W-1:0] above_idx;

  // Scan from the top down so the last hit seen is the lowest qualifying bit.
  always_comb begin
    first_idx   = '0;
    above_found = 1'b0;
    above_idx   = '0;
    for (int i = CH_N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first_idx = IDX_W'(i);
        if (i > int'(cur)) begin
          above_found = 1'b1;
          above_idx   = IDX_W'(i);
        end
      end
    end
  end

  // Prefer a higher channel; otherwise wrap to the lowest set bit when allowed.
  // A single-bit mask therefore wraps back onto the current channel.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    if (above_found) begin
      nxt   = above_idx;
      found = 1'b1;
    end else if (wrap_en && (|mask)) begin
      nxt   = first_idx;
      found = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scans the enabled channels of an 8-bit mask onto a 3-to-8 decoder, with a 1-cycle enable-low gap between channels.
// Latency: start sampled at cycle k gives en=1 on the first channel at k+1; all outputs come straight from flops.
// Backpressure: none; start is ignored while busy, and stop aborts at any time with priority over start.
module decoder_scan_ctrl
  import decoder_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [CH_N-1:0]    ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               sel_a,
  output logic               sel_b,
  output logic               sel_c,
  output logic               en,
  output logic               busy,
  output logic               step,
  output logic               done,
  output logic               err_mask
);

  scan_state_t        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CH_N-1:0]    mask_q, mask_d;
  logic               cont_q, cont_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               en_q, busy_q, step_q, done_q, err_q;
  logic               step_d, done_d, err_d;

  logic [CH_N-1:0]    pick_mask;
  logic [IDX_W-1:0]   pick_nxt, pick_first;
  logic               pick_found;
  logic [DWELL_W-1:0] dwell_load;

  // In IDLE the picker looks at the live mask to find the first channel;
  // once running it only ever sees the copy captured at start.
  assign pick_mask  = (state_q == IDLE) ? ch_mask : mask_q;
  // Counter reload value: dwell of 0 behaves like 1, so the counter never wraps.
  assign dwell_load = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  next_chan_pick u_pick (
    .mask      (pick_mask),
    .cur       (idx_q),
    .wrap_en   (cont_q),
    .nxt       (pick_nxt),
    .found     (pick_found),
    .first_idx (pick_first)
  );

  // Next-state, held-copy and pulse decode; stop is checked first in every state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    cont_d  = cont_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (|ch_mask) begin
            mask_d  = ch_mask;
            cont_d  = continuous;
            dwell_d = dwell_load;
            cnt_d   = dwell_load;
            idx_d   = pick_first;
            state_d = DWELL;
            step_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DWELL: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      GAP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (pick_found) begin
          idx_d   = pick_nxt;
          cnt_d   = dwell_q;
          state_d = DWELL;
          step_d  = 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, held copies and registered outputs; en/busy follow the next state so they leave a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      cont_q  <= 1'b0;
      dwell_q <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      cont_q  <= cont_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      en_q    <= (state_d == DWELL);
      busy_q  <= (state_d != IDLE);
      step_q  <= step_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign sel_a    = idx_q[0];
  assign sel_b    = idx_q[1];
  assign sel_c    = idx_q[2];
  assign en       = en_q;
  assign busy     = busy_q;
  assign step     = step_q;
  assign done     = done_q;
  assign err_mask = err_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: per-cycle comparison against a channel-list trace model.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       continuous = 1'b0;
  logic [7:0] ch_mask = 8'h00;
  logic [7:0] dwell = 8'h00;
  logic       sel_a, sel_b, sel_c, en, busy, step, done, err_mask;

  int checks = 0;
  int fails  = 0;
  logic [2:0] last_sel = 3'd0;

  // Expected per-cycle trace of one scan run.
  bit       e_en   [0:255];
  bit [2:0] e_sel  [0:255];
  bit       e_busy [0:255];
  bit       e_step [0:255];
  bit       e_done [0:255];
  bit       e_err  [0:255];

  decoder_scan_ctrl #(.DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
    .ch_mask(ch_mask), .dwell(dwell), .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c),
    .en(en), .busy(busy), .step(step), .done(done), .err_mask(err_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {en, sel_c, sel_b, sel_a, busy, step, done, err_mask};
  endfunction

  // Trace from the rules: list of set channels, each held D cycles then a gap,
  // repeated if continuous; stop flattens everything after its cycle to idle.
  task automatic build_model(input logic [7:0] m, input logic [7:0] dw, input bit cont,
                             input int stop_at, input int n);
    int d;
    int t;
    int chans[$];
    d = (dw == 8'd0) ? 1 : int'(dw);
    for (int c = 0; c < n; c++) begin
      e_en[c] = 0; e_sel[c] = last_sel; e_busy[c] = 0; e_step[c] = 0; e_done[c] = 0; e_err[c] = 0;
    end
    for (int b = 0; b < 8; b++) if (m[b]) chans.push_back(b);
    if (stop_at == 0) return;
    if (chans.size() == 0) begin
      if (n > 1) e_err[1] = 1;
      return;
    end
    t = 1;
    do begin
      for (int j = 0; j < chans.size(); j++) begin
        for (int k = 0; k < d; k++) begin
          if (t < n) begin
            e_en[t] = 1; e_sel[t] = 3'(chans[j]); e_busy[t] = 1; e_step[t] = (k == 0);
          end
          t++;
        end
        if (t < n) begin
          e_sel[t] = 3'(chans[j]); e_busy[t] = 1;
        end
        t++;
      end
    end while (cont && t < n);
    for (int c = t; c < n; c++) e_sel[c] = 3'(chans[chans.size() - 1]);
    if (t < n) e_done[t] = 1;
    if (stop_at > 0 && stop_at < n) begin
      for (int c = stop_at + 1; c < n; c++) begin
        e_en[c] = 0; e_sel[c] = e_sel[stop_at]; e_busy[c] = 0;
        e_step[c] = 0; e_done[c] = 0; e_err[c] = 0;
      end
    end
  endtask

  // Start a scan at cycle 0 and compare every cycle; optionally scramble the
  // mask/dwell/continuous inputs and pulse start while the scan is running.
  task automatic run_scan(input string name, input logic [7:0] m, input logic [7:0] dw,
                          input bit cont, input int stop_at, input int n, input bit perturb);
    logic [7:0] exp_v;
    logic [7:0] got_v;
    build_model(m, dw, cont, stop_at, n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        ch_mask = m; dwell = dw; continuous = cont; start = 1'b1;
      end else begin
        start = (perturb && e_busy[c]) ? 1'($urandom % 2) : 1'b0;
        if (perturb) begin
          ch_mask    = ($urandom % 2 == 0) ? 8'hFF : 8'($urandom);
          dwell      = 8'($urandom);
          continuous = 1'($urandom % 2);
        end
      end
      stop = (c == stop_at);
      @(negedge clk);
      got_v = obs();
      exp_v = {e_en[c], e_sel[c], e_busy[c], e_step[c], e_done[c], e_err[c]};
      checks++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL %s cycle %0d: got en,sel,busy,step,done,err=%b,%0d,%b,%b,%b,%b want %b,%0d,%b,%b,%b,%b",
                 name, c, got_v[7], got_v[6:4], got_v[3], got_v[2], got_v[1], got_v[0],
                 exp_v[7], exp_v[6:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    last_sel = e_sel[n-1];
  endtask

  task automatic test_reset();
    ch_mask = 8'hFF; dwell = 8'd3; start = 1'b1; rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== 8'h00) begin
        fails++;
        $display("FAIL reset_hold: got %b want 00000000", obs());
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs() !== 8'h00) begin
      fails++;
      $display("FAIL reset_release: got %b want 00000000", obs());
    end
    @(negedge clk);
    checks++;
    if (obs() !== 8'b1_000_1_1_0_0) begin
      fails++;
      $display("FAIL reset_first_en: got %b want 10001100", obs());
    end
    start = 1'b0;
    stop  = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (obs() !== 8'h00) begin
      fails++;
      $display("FAIL reset_stop: got %b want 00000000", obs());
    end
    last_sel = 3'd0;
  endtask

  task automatic test_two_chan();
    run_scan("two_chan", 8'h05, 8'd2, 1'b0, -1, 10, 1'b0);
  endtask

  task automatic test_wrap_stop();
    run_scan("wrap_stop", 8'h81, 8'd1, 1'b1, 10, 14, 1'b0);
    run_scan("single_wrap", 8'h20, 8'd2, 1'b1, 9, 12, 1'b0);
  endtask

  task automatic test_empty_mask();
    run_scan("empty_mask", 8'h00, 8'd3, 1'b0, -1, 4, 1'b0);
    run_scan("empty_mask_stop", 8'h00, 8'd3, 1'b0, 0, 4, 1'b0);
  endtask

  task automatic test_start_stop_same();
    run_scan("start_stop", 8'h3C, 8'd2, 1'b0, 0, 4, 1'b0);
  endtask

  task automatic test_dwell_zero();
    run_scan("dwell_zero", 8'h10, 8'd0, 1'b0, -1, 6, 1'b1);
  endtask

  task automatic test_reset_mid_scan();
    @(posedge clk);
    #1;
    ch_mask = 8'h08; dwell = 8'd6; continuous = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (obs() !== 8'b1_011_1_0_0_0) begin
      fails++;
      $display("FAIL mid_dwell: got %b want 10111000", obs());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 8'h00) begin
      fails++;
      $display("FAIL async_reset: got %b want 00000000", obs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_sel = 3'd0;
    run_scan("after_reset", 8'h0A, 8'd2, 1'b0, -1, 10, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] m;
    logic [7:0] dw;
    bit         cont;
    int         d, pop, t_done, stop_at, n;
    for (int it = 0; it < 12; it++) begin
      m    = 8'($urandom_range(1, 255));
      dw   = 8'($urandom_range(0, 5));
      cont = 1'($urandom % 2);
      d    = (dw == 8'd0) ? 1 : int'(dw);
      pop  = $countones(m);
      t_done = 1 + pop * (d + 1);
      if (cont) begin
        stop_at = $urandom_range(3, 60);
        n = stop_at + 3;
      end else begin
        stop_at = ($urandom % 3 == 0) ? $urandom_range(1, t_done) : -1;
        n = t_done + 3;
      end
      run_scan("random", m, dw, cont, stop_at, n, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_two_chan();
    test_wrap_stop();
    test_empty_mask();
    test_start_stop_same();
    test_dwell_zero();
    test_reset_mid_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
